// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUControl encodings for the ALU control decoder and
//               the execute stage. Both sides import these constants so the
//               code map is defined in exactly one place.
// Contents    : alu_ctrl_t, ALU_* code constants, is_legal() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   typedef logic [3:0] alu_ctrl_t;

   localparam alu_ctrl_t ALU_ADD     = 4'b0000;
   localparam alu_ctrl_t ALU_SUB     = 4'b0001;
   localparam alu_ctrl_t ALU_AND     = 4'b0010;
   localparam alu_ctrl_t ALU_OR      = 4'b0011;
   localparam alu_ctrl_t ALU_SLT     = 4'b0101;
   localparam alu_ctrl_t ALU_ILLEGAL = 4'b1111;

   // True for the five codes the execute stage implements.
   function automatic logic is_legal(input alu_ctrl_t ctrl);
      return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) ||
             (ctrl == ALU_OR)  || (ctrl == ALU_SLT);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_if
// Description : Valid/ready bus into and out of the ALU execute stage.
//               Input side : in_valid, in_ready, alu_ctrl, src_a, src_b, tag_in
//               Output side: out_valid, out_ready, result, zero, illegal, tag_out
//               master = pipeline side (drives ops, accepts results)
//               slave  = execute stage
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_stage_if
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int TAGW = 5
);
   logic            in_valid;
   logic            in_ready;
   alu_ctrl_t       alu_ctrl;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [TAGW-1:0] tag_in;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;
   logic [TAGW-1:0] tag_out;

   modport master (
      output in_valid, alu_ctrl, src_a, src_b, tag_in, out_ready,
      input  in_ready, out_valid, result, zero, illegal, tag_out
   );

   modport slave (
      input  in_valid, alu_ctrl, src_a, src_b, tag_in, out_ready,
      output in_ready, out_valid, result, zero, illegal, tag_out
   );
endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU evaluating one ALUControl code.
// Ports       : i_ctrl    ALUControl code
//               i_a, i_b  operands
//               o_result  result (0 for unsupported codes)
//               o_zero    result == 0, forced low for unsupported codes
//               o_illegal code is unsupported
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_ctrl_t       i_ctrl,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_result,
   output logic            o_zero,
   output logic            o_illegal
);

   always_comb begin
      o_result  = '0;
      o_illegal = !is_legal(i_ctrl);
      case (i_ctrl)
         ALU_ADD: o_result = i_a + i_b;
         ALU_SUB: o_result = i_a - i_b;
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_SLT: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default: o_result = '0;
      endcase
      // An illegal op must never look like a taken branch compare.
      o_zero = !o_illegal && (o_result == '0);
   end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Execute stage behind the ALU control decoder. Accepts ops over
//               a valid/ready handshake, evaluates them in alu_core and holds
//               results in an output register (OR) backed by a skid register
//               (SK) so back-pressure never drops an op. Counts accepted
//               unsupported codes (saturating) for debug.
// Ports       : clk         clock, rising edge
//               rst_n       asynchronous active-low reset
//               flush       synchronous pipeline flush, highest priority
//               bus         valid/ready op/result bus (slave side)
//               illegal_cnt saturating count of accepted illegal ops
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int TAGW = 5,
   parameter int CNTW = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   alu_exec_stage_if.slave     bus,
   output logic [CNTW-1:0]     illegal_cnt
);

   localparam logic [CNTW-1:0] c_CNT_MAX = '1;

   logic [XLEN-1:0] w_result;
   logic            w_zero;
   logic            w_illegal;
   logic            w_accept;
   logic            w_or_free;

   logic            r_or_valid;
   logic [XLEN-1:0] r_or_result;
   logic            r_or_zero;
   logic            r_or_illegal;
   logic [TAGW-1:0] r_or_tag;

   logic            r_sk_valid;
   logic [XLEN-1:0] r_sk_result;
   logic            r_sk_zero;
   logic            r_sk_illegal;
   logic [TAGW-1:0] r_sk_tag;

   logic [CNTW-1:0] r_illegal_cnt;

   alu_core #(.XLEN(XLEN)) u_alu_core (
      .i_ctrl    (bus.alu_ctrl),
      .i_a       (bus.src_a),
      .i_b       (bus.src_b),
      .o_result  (w_result),
      .o_zero    (w_zero),
      .o_illegal (w_illegal)
   );

   // in_ready is a pure function of the SK valid flop, so it is registered.
   // An offer during flush is discarded, never accepted.
   assign w_accept  = bus.in_valid && !r_sk_valid && !flush;
   // OR can take a new entry when it is empty or draining this edge.
   assign w_or_free = !r_or_valid || bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_or_valid   <= 1'b0;
         r_or_result  <= '0;
         r_or_zero    <= 1'b0;
         r_or_illegal <= 1'b0;
         r_or_tag     <= '0;
         r_sk_valid   <= 1'b0;
         r_sk_result  <= '0;
         r_sk_zero    <= 1'b0;
         r_sk_illegal <= 1'b0;
         r_sk_tag     <= '0;
      end else if (flush) begin
         r_or_valid <= 1'b0;
         r_sk_valid <= 1'b0;
      end else if (w_or_free) begin
         if (r_sk_valid) begin
            // Older SK entry goes first; no accept possible since in_ready=0.
            r_or_valid   <= 1'b1;
            r_or_result  <= r_sk_result;
            r_or_zero    <= r_sk_zero;
            r_or_illegal <= r_sk_illegal;
            r_or_tag     <= r_sk_tag;
            r_sk_valid   <= 1'b0;
         end else if (w_accept) begin
            r_or_valid   <= 1'b1;
            r_or_result  <= w_result;
            r_or_zero    <= w_zero;
            r_or_illegal <= w_illegal;
            r_or_tag     <= bus.tag_in;
         end else begin
            r_or_valid <= 1'b0;
         end
      end else if (w_accept) begin
         // OR stalled: park the new op in SK, holding OR outputs steady.
         r_sk_valid   <= 1'b1;
         r_sk_result  <= w_result;
         r_sk_zero    <= w_zero;
         r_sk_illegal <= w_illegal;
         r_sk_tag     <= bus.tag_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_cnt <= '0;
      end else if (w_accept && w_illegal && (r_illegal_cnt != c_CNT_MAX)) begin
         r_illegal_cnt <= r_illegal_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = !r_sk_valid;
   assign bus.out_valid = r_or_valid;
   assign bus.result    = r_or_result;
   assign bus.zero      = r_or_zero;
   assign bus.illegal   = r_or_illegal;
   assign bus.tag_out   = r_or_tag;
   assign illegal_cnt   = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Directed self-checking bench for alu_exec_stage. A second
//               instance with CNTW=2 covers counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;
   import alu_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       flush2;
   logic [7:0] illegal_cnt;
   logic [1:0] illegal_cnt2;
   int         errors;
   int         checks;

   alu_exec_stage_if #(.XLEN(32), .TAGW(5)) bus  ();
   alu_exec_stage_if #(.XLEN(32), .TAGW(5)) bus2 ();

   alu_exec_stage #(.XLEN(32), .TAGW(5), .CNTW(8)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus.slave),
      .illegal_cnt (illegal_cnt)
   );

   alu_exec_stage #(.XLEN(32), .TAGW(5), .CNTW(2)) u_dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush2),
      .bus         (bus2.slave),
      .illegal_cnt (illegal_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input alu_ctrl_t c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t);
      bus.in_valid = v;
      bus.alu_ctrl = c;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.tag_in   = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      flush2 = 1'b0;
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      bus.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.alu_ctrl = ALU_ADD; bus2.src_a = '0;
      bus2.src_b = '0; bus2.tag_in = '0; bus2.out_ready = 1'b1;
      tick(); tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.result !== 32'd0 || bus.zero !== 1'b0 || bus.illegal !== 1'b0 || bus.tag_out !== 5'd0)
         begin errors++; $display("FAIL reset_outputs got=%h/%b/%b/%h exp=0/0/0/0", bus.result, bus.zero, bus.illegal, bus.tag_out); end
      checks++; if (illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
      rst_n = 1'b1;
      tick();
   endtask

   // Streaming ops with out_ready=1: each result appears one edge after accept.
   task automatic test_ops();
      alu_ctrl_t   c  [6] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_ADD, ALU_AND, ALU_OR};
      logic [31:0] a  [6] = '{32'h5, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_00FF, 32'hF000_0000};
      logic [31:0] b  [6] = '{32'h3, 32'h1234_5678, 32'h1, 32'h1, 32'h0FF0_0F0F, 32'h0000_000F};
      logic [31:0] r  [6] = '{32'h8, 32'h0, 32'h1, 32'h0, 32'h00F0_000F, 32'hF000_000F};
      logic        z  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, c[i], a[i], b[i], 5'(i + 4));
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== r[i] || bus.zero !== z[i] ||
             bus.illegal !== 1'b0 || bus.tag_out !== 5'(i + 4))
         begin
            errors++;
            $display("FAIL op%0d got v=%b r=%h z=%b il=%b t=%0d exp v=1 r=%h z=%b il=0 t=%0d",
                     i, bus.out_valid, bus.result, bus.zero, bus.illegal, bus.tag_out, r[i], z[i], i + 4);
         end
      end
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b0;
      drive(1'b1, ALU_ADD, 32'd1, 32'd0, 5'd1);
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.tag_out !== 5'd1 || bus.in_ready !== 1'b1)
         begin errors++; $display("FAIL b2b_first got v=%b t=%0d rdy=%b exp 1/1/1", bus.out_valid, bus.tag_out, bus.in_ready); end
      drive(1'b1, ALU_ADD, 32'd2, 32'd0, 5'd2);
      tick();
      checks++; if (bus.in_ready !== 1'b0 || bus.tag_out !== 5'd1 || bus.result !== 32'd1)
         begin errors++; $display("FAIL b2b_full got rdy=%b t=%0d r=%h exp 0/1/1", bus.in_ready, bus.tag_out, bus.result); end
      drive(1'b1, ALU_ADD, 32'd3, 32'd0, 5'd3);
      tick();
      checks++; if (bus.in_ready !== 1'b0 || bus.tag_out !== 5'd1 || bus.result !== 32'd1 || bus.out_valid !== 1'b1)
         begin errors++; $display("FAIL b2b_hold got rdy=%b t=%0d r=%h v=%b exp 0/1/1/1", bus.in_ready, bus.tag_out, bus.result, bus.out_valid); end
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.tag_out !== 5'd2 || bus.result !== 32'd2 || bus.in_ready !== 1'b1)
         begin errors++; $display("FAIL b2b_second got v=%b t=%0d r=%h rdy=%b exp 1/2/2/1", bus.out_valid, bus.tag_out, bus.result, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.tag_out !== 5'd3 || bus.result !== 32'd3)
         begin errors++; $display("FAIL b2b_third got v=%b t=%0d r=%h exp 1/3/3", bus.out_valid, bus.tag_out, bus.result); end
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got v=%b exp 0 t=%0d", bus.out_valid, bus.tag_out); end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      drive(1'b1, ALU_ILLEGAL, 32'd5, 32'd3, 5'd9);
      tick();
      checks++; if (bus.illegal !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b0 || bus.tag_out !== 5'd9 || illegal_cnt !== 8'd1)
         begin errors++; $display("FAIL illegal_1111 got il=%b r=%h z=%b t=%0d cnt=%0d exp 1/0/0/9/1", bus.illegal, bus.result, bus.zero, bus.tag_out, illegal_cnt); end
      drive(1'b1, 4'b0100, 32'd0, 32'd0, 5'd10);
      tick();
      checks++; if (bus.illegal !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b0 || illegal_cnt !== 8'd2)
         begin errors++; $display("FAIL illegal_0100 got il=%b r=%h z=%b cnt=%0d exp 1/0/0/2", bus.illegal, bus.result, bus.zero, illegal_cnt); end
      drive(1'b1, ALU_ADD, 32'd1, 32'd1, 5'd11);
      tick();
      checks++; if (bus.illegal !== 1'b0 || bus.result !== 32'd2 || illegal_cnt !== 8'd2)
         begin errors++; $display("FAIL legal_after got il=%b r=%h cnt=%0d exp 0/2/2", bus.illegal, bus.result, illegal_cnt); end
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      tick();
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      bus2.out_ready = 1'b1;
      bus2.alu_ctrl  = ALU_ILLEGAL;
      bus2.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (illegal_cnt2 !== exp_cnt[i])
            begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, illegal_cnt2, exp_cnt[i]); end
      end
      bus2.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      // Flush with both entries full.
      bus.out_ready = 1'b0;
      drive(1'b1, ALU_ADD, 32'd10, 32'd0, 5'd10);
      tick();
      drive(1'b1, ALU_ADD, 32'd11, 32'd0, 5'd11);
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_pre got rdy=%b exp 0", bus.in_ready); end
      flush = 1'b1;
      drive(1'b1, ALU_ILLEGAL, 32'd12, 32'd0, 5'd12);
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || illegal_cnt !== 8'd2)
         begin errors++; $display("FAIL flush_full got v=%b rdy=%b cnt=%0d exp 0/1/2", bus.out_valid, bus.in_ready, illegal_cnt); end
      // Flush with empty buffers: the offered illegal op is discarded.
      tick();
      flush = 1'b0;
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      bus.out_ready = 1'b1;
      checks++; if (bus.out_valid !== 1'b0 || illegal_cnt !== 8'd2)
         begin errors++; $display("FAIL flush_empty got v=%b cnt=%0d exp 0/2", bus.out_valid, illegal_cnt); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%b t=%0d exp 0", bus.out_valid, bus.tag_out); end
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      drive(1'b1, ALU_ILLEGAL, 32'd0, 32'd0, 5'd20);
      tick();
      drive(1'b1, ALU_ADD, 32'd7, 32'd0, 5'd21);
      tick();
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      checks++; if (illegal_cnt !== 8'd3 || bus.in_ready !== 1'b0)
         begin errors++; $display("FAIL areset_pre got cnt=%0d rdy=%b exp 3/0", illegal_cnt, bus.in_ready); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || illegal_cnt !== 8'd0 || bus.in_ready !== 1'b1 || bus.tag_out !== 5'd0)
         begin errors++; $display("FAIL areset_now got v=%b cnt=%0d rdy=%b t=%0d exp 0/0/1/0", bus.out_valid, illegal_cnt, bus.in_ready, bus.tag_out); end
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      drive(1'b1, ALU_ADD, 32'd5, 32'd3, 5'd1);
      tick();
      drive(1'b0, ALU_ADD, 32'd0, 32'd0, 5'd0);
      checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd8 || bus.zero !== 1'b0 || bus.illegal !== 1'b0)
         begin errors++; $display("FAIL areset_after got v=%b r=%h z=%b il=%b exp 1/8/0/0", bus.out_valid, bus.result, bus.zero, bus.illegal); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_ops();
      test_back_to_back();
      test_illegal();
      test_saturate();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
